// File: rtl/rv_immgen.sv
// RISC-V immediate generator with a valid/ready output buffer.
// Latency: 1 cycle from an accepted input to o_immgen_valid when the buffer is empty.
// Backpressure: SKID=1 uses a 2-entry skid buffer with registered ready; SKID=0 uses one stage.
//
// Ports:
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_immgen_valid/ready  upstream handshake (o_immgen_ready out)
//   i_immgen_instr_31to7  instruction bits 31..7
//   i_immgen_ctrl         format select I/S/B/U/J/Z = 0..5, 6/7 illegal
//   i_immgen_tag          sideband carried with the entry
//   i_immgen_flush        drop every held and incoming entry
//   o_immgen_valid/i_immgen_ready  downstream handshake
//   o_immgen_ext_imm, o_immgen_tag, o_immgen_illegal  output payload
module rv_immgen #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int SKID  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_immgen_valid,
  output logic             o_immgen_ready,
  input  logic [31:7]      i_immgen_instr_31to7,
  input  logic [2:0]       i_immgen_ctrl,
  input  logic [TAG_W-1:0] i_immgen_tag,
  input  logic             i_immgen_flush,
  output logic             o_immgen_valid,
  input  logic             i_immgen_ready,
  output logic [XLEN-1:0]  o_immgen_ext_imm,
  output logic [TAG_W-1:0] o_immgen_tag,
  output logic             o_immgen_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_Z = 3'd5;

  logic [1:0]       state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic             main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;

  logic [XLEN-1:0]  imm_c;
  logic             ill_c;
  logic             in_xfer, out_xfer;

  // Immediate decode. Size casts of signed operands sign-extend to XLEN.
  always_comb begin
    imm_c = '0;
    ill_c = 1'b0;
    case (i_immgen_ctrl)
      FMT_I: imm_c = XLEN'($signed(i_immgen_instr_31to7[31:20]));
      FMT_S: imm_c = XLEN'($signed({i_immgen_instr_31to7[31:25], i_immgen_instr_31to7[11:7]}));
      FMT_B: imm_c = XLEN'($signed({i_immgen_instr_31to7[31], i_immgen_instr_31to7[7],
                                    i_immgen_instr_31to7[30:25], i_immgen_instr_31to7[11:8], 1'b0}));
      FMT_U: imm_c = XLEN'($signed({i_immgen_instr_31to7[31:12], 12'b0}));
      FMT_J: imm_c = XLEN'($signed({i_immgen_instr_31to7[31], i_immgen_instr_31to7[19:12],
                                    i_immgen_instr_31to7[20], i_immgen_instr_31to7[30:21], 1'b0}));
      FMT_Z: imm_c = XLEN'(i_immgen_instr_31to7[19:15]);
      default: ill_c = 1'b1;
    endcase
  end

  assign o_immgen_valid = (state_q != ST_EMPTY);
  // rdy_q is low only in reset or in TWO; in single-stage mode it also gates
  // the combinational pass-through ready so reset holds ready low.
  assign o_immgen_ready = (SKID != 0) ? rdy_q
                                      : (rdy_q & (~o_immgen_valid | i_immgen_ready));
  assign in_xfer  = i_immgen_valid & o_immgen_ready;
  assign out_xfer = o_immgen_valid & i_immgen_ready;

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_tag_d = main_tag_q;
    main_ill_d = main_ill_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    skid_ill_d = skid_ill_q;
    if (i_immgen_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_imm_d = imm_c;
            main_tag_d = i_immgen_tag;
            main_ill_d = ill_c;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_imm_d = imm_c;
            main_tag_d = i_immgen_tag;
            main_ill_d = ill_c;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: single-stage ready implies out_xfer here.
            skid_imm_d = imm_c;
            skid_tag_d = i_immgen_tag;
            skid_ill_d = ill_c;
            state_d    = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            main_ill_d = skid_ill_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    rdy_d = (state_d != ST_TWO);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_EMPTY;
      rdy_q      <= 1'b0;
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_ill_q <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      main_ill_q <= main_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign o_immgen_ext_imm = main_imm_q;
  assign o_immgen_tag     = main_tag_q;
  assign o_immgen_illegal = main_ill_q;

endmodule

// File: tb/tb_rv_immgen.sv
// Directed bench for rv_immgen: a 32-bit skid-buffer instance and a 64-bit single-stage instance.
module tb_rv_immgen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit, SKID=1 instance
  logic        in_vld, up_rdy, flush, dn_rdy, out_vld, out_ill;
  logic [31:7] in_instr;
  logic [2:0]  in_ctrl;
  logic [31:0] in_tag, out_imm, out_tag;

  rv_immgen #(.XLEN(32), .TAG_W(32), .SKID(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_immgen_valid(in_vld), .o_immgen_ready(up_rdy),
    .i_immgen_instr_31to7(in_instr), .i_immgen_ctrl(in_ctrl),
    .i_immgen_tag(in_tag), .i_immgen_flush(flush),
    .o_immgen_valid(out_vld), .i_immgen_ready(dn_rdy),
    .o_immgen_ext_imm(out_imm), .o_immgen_tag(out_tag),
    .o_immgen_illegal(out_ill)
  );

  // 64-bit, SKID=0 instance
  logic        v64, ur64, fl64, dr64, ov64, oill64;
  logic [31:7] i64;
  logic [2:0]  c64;
  logic [7:0]  t64, otag64;
  logic [63:0] oimm64;

  rv_immgen #(.XLEN(64), .TAG_W(8), .SKID(0)) dut64 (
    .i_clk(clk), .i_rst(rst),
    .i_immgen_valid(v64), .o_immgen_ready(ur64),
    .i_immgen_instr_31to7(i64), .i_immgen_ctrl(c64),
    .i_immgen_tag(t64), .i_immgen_flush(fl64),
    .o_immgen_valid(ov64), .i_immgen_ready(dr64),
    .o_immgen_ext_imm(oimm64), .o_immgen_tag(otag64),
    .o_immgen_illegal(oill64)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] c, input logic [31:0] t);
    in_instr = ins[31:7];
    in_ctrl  = c;
    in_tag   = t;
    in_vld   = 1'b1;
  endtask

  // One entry through an empty buffer with downstream ready.
  task automatic single(input string nm, input logic [31:0] ins, input logic [2:0] c,
                        input logic [31:0] t, input logic [31:0] eimm, input logic eill);
    @(negedge clk);
    dn_rdy = 1'b1;
    drive(ins, c, t);
    @(negedge clk);
    in_vld = 1'b0;
    chk_eq({nm, "_vld"}, out_vld, 1);
    chk_eq({nm, "_imm"}, out_imm, eimm);
    chk_eq({nm, "_tag"}, out_tag, t);
    chk_eq({nm, "_ill"}, out_ill, eill);
    @(negedge clk);
    chk_eq({nm, "_drain"}, out_vld, 0);
  endtask

  logic [31:0] s_ins [4];
  logic [31:0] s_exp [4];
  int          acc, got;
  bit          seen_low, prev_stall, seen_vld;
  logic [31:0] held_imm, held_tag;

  initial begin
    in_vld = 0; flush = 0; dn_rdy = 0; in_instr = '0; in_ctrl = '0; in_tag = '0;
    v64 = 0; fl64 = 0; dr64 = 0; i64 = '0; c64 = '0; t64 = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("rst_vld", out_vld, 0);
    chk_eq("rst_rdy", up_rdy, 0);
    chk_eq("rst_imm", out_imm, 0);
    chk_eq("rst_tag", out_tag, 0);
    chk_eq("rst_ill", out_ill, 0);
    chk_eq("rst_rdy64", ur64, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_rdy", up_rdy, 1);
    chk_eq("post_rst_vld", out_vld, 0);
    chk_eq("post_rst_rdy64", ur64, 1);

    // Format decode
    single("i_neg",  32'hFFF00093, 3'd0, 32'h100, 32'hFFFFFFFF, 1'b0);
    single("i_pos",  32'h7FF00093, 3'd0, 32'h101, 32'h000007FF, 1'b0);
    single("s_neg",  32'hFE112E23, 3'd1, 32'h102, 32'hFFFFFFFC, 1'b0);
    single("b_neg",  32'hFE000EE3, 3'd2, 32'h103, 32'hFFFFFFFC, 1'b0);
    single("u_32",   32'h123450B7, 3'd3, 32'h104, 32'h12345000, 1'b0);
    single("j_neg",  32'hFF9FF06F, 3'd4, 32'h105, 32'hFFFFFFF8, 1'b0);
    single("z_1f",   32'h000F8073, 3'd5, 32'h106, 32'h0000001F, 1'b0);
    single("z_msb",  32'h800F8073, 3'd5, 32'h107, 32'h0000001F, 1'b0);
    single("ill_7",  32'hFFFFFFFF, 3'd7, 32'h108, 32'h00000000, 1'b1);
    single("ill_6",  32'h123450B7, 3'd6, 32'h109, 32'h00000000, 1'b1);

    // Backpressure: 4 back-to-back entries, downstream stalled 3 cycles
    s_ins[0] = 32'h00100093; s_exp[0] = 32'h00000001;
    s_ins[1] = 32'h00200093; s_exp[1] = 32'h00000002;
    s_ins[2] = 32'hFFF00093; s_exp[2] = 32'hFFFFFFFF;
    s_ins[3] = 32'h80000093; s_exp[3] = 32'hFFFFF800;
    acc = 0; got = 0; seen_low = 0; prev_stall = 0;
    held_imm = '0; held_tag = '0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk_eq("bp_stable_imm", out_imm, held_imm);
        chk_eq("bp_stable_tag", out_tag, held_tag);
      end
      dn_rdy = (k >= 4);
      if (acc < 4) drive(s_ins[acc], 3'd0, acc + 1);
      else in_vld = 1'b0;
      if (!up_rdy && !seen_low) begin
        seen_low = 1;
        chk_eq("bp_acc_at_drop", acc, 2);
      end
      if (in_vld && up_rdy) acc++;
      if (out_vld && dn_rdy) begin
        chk_eq($sformatf("bp_out%0d_imm", got), out_imm, s_exp[got]);
        chk_eq($sformatf("bp_out%0d_tag", got), out_tag, got + 1);
        got++;
      end
      prev_stall = out_vld && !dn_rdy;
      held_imm = out_imm;
      held_tag = out_tag;
    end
    in_vld = 1'b0;
    chk_eq("bp_all_out", got, 4);
    chk_eq("bp_all_in", acc, 4);
    chk_eq("bp_ready_dropped", seen_low, 1);
    @(negedge clk);
    chk_eq("bp_drain", out_vld, 0);

    // Flush with two held entries plus a valid input
    dn_rdy = 1'b0;
    drive(32'h00300093, 3'd0, 32'hA);
    @(negedge clk);
    drive(32'h00400093, 3'd0, 32'hB);
    @(negedge clk);
    chk_eq("fl_two_rdy", up_rdy, 0);
    drive(32'h00500093, 3'd0, 32'hC);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_vld = 1'b0;
    chk_eq("fl_vld", out_vld, 0);
    chk_eq("fl_rdy", up_rdy, 1);
    dn_rdy = 1'b1;
    seen_vld = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_vld) seen_vld = 1;
    end
    chk_eq("fl_no_emit", seen_vld, 0);

    // Flush discards an input accepted while empty
    drive(32'h00600093, 3'd0, 32'hD);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_vld = 1'b0;
    chk_eq("fl_empty_in", out_vld, 0);

    // Reset mid-stream
    @(negedge clk);
    dn_rdy = 1'b0;
    drive(32'h00700093, 3'd0, 32'hE);
    @(negedge clk);
    drive(32'h00800093, 3'd0, 32'hF);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk_eq("mrst_vld", out_vld, 0);
    chk_eq("mrst_rdy", up_rdy, 0);
    chk_eq("mrst_imm", out_imm, 0);
    chk_eq("mrst_tag", out_tag, 0);
    rst = 1'b0;
    flush = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    chk_eq("mrst_rel_rdy", up_rdy, 1);
    chk_eq("mrst_rel_vld", out_vld, 0);

    // 64-bit single-stage instance
    @(negedge clk);
    dr64 = 1'b0;
    i64 = 25'h1000001; // 0x800000B7 >> 7
    c64 = 3'd3; t64 = 8'h5A; v64 = 1'b1;
    @(negedge clk);
    chk_eq("x64_u_vld", ov64, 1);
    chk_eq("x64_u_imm", oimm64, 64'hFFFFFFFF80000000);
    chk_eq("x64_u_tag", otag64, 8'h5A);
    chk_eq("x64_stall_rdy", ur64, 0);
    i64 = 25'h1FFE001; // 0xFFF00093 >> 7
    c64 = 3'd0; t64 = 8'hA5;
    @(negedge clk);
    chk_eq("x64_hold_imm", oimm64, 64'hFFFFFFFF80000000);
    dr64 = 1'b1;
    #1;
    chk_eq("x64_pass_rdy", ur64, 1);
    @(negedge clk);
    v64 = 1'b0;
    chk_eq("x64_i_vld", ov64, 1);
    chk_eq("x64_i_imm", oimm64, 64'hFFFFFFFFFFFFFFFF);
    chk_eq("x64_i_tag", otag64, 8'hA5);
    @(negedge clk);
    chk_eq("x64_drain", ov64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
